// File: rtl/onchip_ram_arbiter.sv
// onchip_ram_arbiter: two-master arbiter for the single-port on-chip RAM, M0 fixed priority with M1 anti-starvation
module onchip_ram_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              m_read,
    input  logic [1:0]              m_write,
    input  logic [2*ADDR_W-1:0]     m_address,
    input  logic [2*DATA_W/8-1:0]   m_byteenable,
    input  logic [2*DATA_W-1:0]     m_writedata,
    output logic [1:0]              m_waitrequest,
    output logic [DATA_W-1:0]       m_readdata,
    output logic [1:0]              m_readdatavalid,
    output logic                    ram_chipselect,
    output logic                    ram_write,
    output logic [ADDR_W-1:0]       ram_address,
    output logic [DATA_W/8-1:0]     ram_byteenable,
    output logic [DATA_W-1:0]       ram_writedata,
    output logic                    ram_clken,
    input  logic [DATA_W-1:0]       ram_readdata
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    logic [1:0]              w_req;
    logic [1:0]              w_grant;
    logic                    w_sel;
    logic                    w_rd;
    logic [3:0]              r_starve;
    logic [READ_LATENCY-1:0] r_v;
    logic [READ_LATENCY-1:0] r_id;

    assign w_req = m_read | m_write;

    // Grant: lone requester wins; on contention M0 wins unless M1 has waited STARVE_LIMIT cycles
    always_comb begin
        w_grant = 2'b00;
        if (reset_n)
            w_grant = (&w_req) ? ((r_starve == LIM) ? 2'b10 : 2'b01) : w_req;
    end

    assign w_sel          = w_grant[1];
    assign w_rd           = |(w_grant & m_read & ~m_write);
    assign m_waitrequest  = ~w_grant;
    assign ram_chipselect = |w_grant;
    assign ram_write      = |(w_grant & m_write);
    assign ram_address    = w_sel ? m_address[ADDR_W +: ADDR_W] : m_address[0 +: ADDR_W];
    assign ram_byteenable = w_sel ? m_byteenable[BE_W +: BE_W] : m_byteenable[0 +: BE_W];
    assign ram_writedata  = w_sel ? m_writedata[DATA_W +: DATA_W] : m_writedata[0 +: DATA_W];
    assign ram_clken      = 1'b1;
    assign m_readdata     = ram_readdata;
    assign m_readdatavalid = (reset_n && r_v[READ_LATENCY-1])
                           ? (r_id[READ_LATENCY-1] ? 2'b10 : 2'b01) : 2'b00;

    // Starvation counter: counts M1 request cycles lost to M0, saturating at the limit
    always_ff @(posedge clk) begin
        if (!reset_n || !w_req[1] || w_grant[1])
            r_starve <= 4'd0;
        else if (w_grant[0] && r_starve != LIM)
            r_starve <= r_starve + 4'd1;
    end

    // Read tag pipeline: follows each accepted read so its return strobe reaches the issuer only
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_v  <= '0;
            r_id <= '0;
        end else begin
            r_v[0]  <= w_rd;
            r_id[0] <= w_sel;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_v[k]  <= r_v[k-1];
                r_id[k] <= r_id[k-1];
            end
        end
    end
endmodule

// File: doc/onchip_ram_arbiter.md
Name:
onchip_ram_arbiter

Overview:
Two-master arbiter that shares the single-port on-chip program/data RAM (8192 x 32, byte-enabled, 1-cycle read) between master 0 (NIOS data master) and master 1 (accelerator DMA). M0 has fixed priority. M1 has a starvation guarantee. Read returns are tagged so that readdatavalid reaches only the issuing master. Sits between the two Avalon-MM masters and the RAM's s1 port.

Parameters:
ADDR_W, 13, word address width
DATA_W, 32, data width; byte-enable width is DATA_W/8
STARVE_LIMIT, 4, max consecutive cycles M1 may request without grant (1..15)
READ_LATENCY, 1, RAM address-to-data cycles (1 or 2)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
m_read  in  2  read request, bit i = master i
m_write  in  2  write request, bit i = master i
m_address  in  2*ADDR_W  master i at [i*ADDR_W +: ADDR_W]
m_byteenable  in  2*DATA_W/8  per-master byte enables
m_writedata  in  2*DATA_W  per-master write data
m_waitrequest  out  2  bit i high = master i not accepted this cycle
m_readdata  out  DATA_W  read data broadcast to both masters
m_readdatavalid  out  2  one-hot return strobe
ram_chipselect  out  1  RAM access this cycle
ram_write  out  1  RAM write enable
ram_address  out  ADDR_W  RAM address
ram_byteenable  out  DATA_W/8  RAM byte enables
ram_writedata  out  DATA_W  RAM write data
ram_clken  out  1  tied 1
ram_readdata  in  DATA_W  RAM read data

Behaviour:
- Clock is clk. Reset is synchronous and active-low (reset_n). The only edge is the rising edge of clk.
- req[i] = m_read[i] | m_write[i]. If both are set on one master, treat it as a write: no readdatavalid is produced.
- Grant is combinational in the same cycle:
  - only one requester -> that master;
  - both requesting -> M1 if starve_cnt == STARVE_LIMIT, else M0;
  - no request -> no grant.
- m_waitrequest[i] = ~grant[i], so waitrequest is high while idle. A transfer completes in the cycle where req[i] & ~m_waitrequest[i]. Zero-wait acceptance.
- RAM side is a combinational mux of the granted master's fields. ram_chipselect = any grant. ram_write = granted master's write. With no grant, ram_chipselect=0 and ram_write=0.
- starve_cnt is 4 bits, registered:
  - cleared when M1 is granted or M1 is not requesting;
  - incremented when M1 requests and M0 is granted;
  - saturates at STARVE_LIMIT.
- Read return tracking:
  - tag pipeline of depth READ_LATENCY, each stage {valid, id}, loaded with {granted read, grant id} every cycle;
  - at the last stage, m_readdatavalid[id] = valid;
  - m_readdata = ram_readdata unconditionally.
- Back-to-back reads from alternating masters are supported, one accept per cycle. Return order equals issue order.
- Read-during-write to the same address from different masters on consecutive cycles: the RAM's returned data is undefined (DONT_CARE). The arbiter does not forward.
- Reset (reset_n low at a clock edge):
  - starve_cnt=0, tag pipeline cleared;
  - m_readdatavalid=0 from the next cycle;
  - reads in flight are discarded, never returned.
- While reset_n is low, grants are forced to 0: m_waitrequest=2'b11, ram_chipselect=0, ram_write=0.
- Outputs after reset: m_waitrequest=2'b11 (until a request arrives), m_readdatavalid=0, ram_chipselect=0, ram_write=0, ram_clken=1. ram_address, ram_byteenable and ram_writedata are don't-care but muxed from M0.

Test Plan:
- M0 write 0x0000_1234 to addr 0x010 (be=4'hF), then M0 read 0x010 -> waitrequest[0]=0 both cycles; one cycle after the read, readdatavalid=2'b01, readdata=0x0000_1234.
- M1 alone reads addr 0x1FFF for 3 back-to-back cycles -> no wait; readdatavalid=2'b10 for 3 cycles starting 1 cycle later.
- Both request continuously (M0 reads, M1 writes), STARVE_LIMIT=4 -> M1 granted on every 5th cycle (cycles 5, 10, ...); M0 waitrequest high exactly on those cycles; starve_cnt returns to 0 after each M1 grant.
- Alternating M0/M1 reads of addrs 0x001 and 0x002 (preloaded 0xA, 0xB) -> readdatavalid sequence 01,10,01 with readdata 0xA,0xB,0xA.
- M0 issues a read, reset_n is low on the next edge -> no readdatavalid is produced; during reset m_waitrequest=2'b11 and ram_chipselect=0.
- M0 asserts read and write together with be=4'b0011, data 0xFFFF_FFFF, to addr 0x020 (previously 0) -> write occurs; no readdatavalid; a later read of 0x020 returns 0x0000_FFFF.
